// File: rtl/icache_sa_pkg.sv
// Shared types and address-geometry helpers for the set-associative I-cache.
package icache_sa_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  // Line address (byte address without the offset) for the default 32-bit / 256-bit geometry.
  typedef logic [26:0] line_addr_t;

  function automatic int offset_w(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_bits, input int num_sets);
    return addr_w - offset_w(line_bits) - index_w(num_sets);
  endfunction

  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/icache_sa_way.sv
// One way of the I-cache: per-set tag/valid/data flops plus the hit compare.
module icache_sa_way
  import icache_sa_pkg::*;
#(
  parameter int NUM_SETS  = 8,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [index_w(NUM_SETS)-1:0]  lookup_index,
  input  logic [TAG_W-1:0]              lookup_tag,
  output logic                          hit,
  output logic [LINE_BITS-1:0]          lookup_line,
  input  logic [index_w(NUM_SETS)-1:0]  fill_index,
  output logic                          fill_valid,
  input  logic                          fill_en,
  input  logic [TAG_W-1:0]              fill_tag,
  input  logic [LINE_BITS-1:0]          fill_line,
  input  logic                          clear_en,
  input  logic [index_w(NUM_SETS)-1:0]  clear_index
);

  logic [NUM_SETS-1:0]  valid;
  logic [TAG_W-1:0]     tags  [NUM_SETS];
  logic [LINE_BITS-1:0] lines [NUM_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear_en) begin
      valid[clear_index] <= 1'b0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone define
  // whether a line means anything, so the payload needs no reset tree.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_index]  <= fill_tag;
      lines[fill_index] <= fill_line;
    end
  end

  assign hit         = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign lookup_line = lines[lookup_index];
  assign fill_valid  = valid[fill_index];

endmodule

// File: rtl/icache_sa.sv
// Set-associative read-only I-cache: lookup, line fill with round-robin
// replacement, and a one-set-per-cycle invalidate-all walk.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int NUM_SETS  = 8,
  parameter int NUM_WAYS  = 2,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic [ADDR_W-1:0]    mem_address,
  output logic                 mem_resp,
  output logic [31:0]          mem_rdata,
  input  logic                 flush,
  output logic                 flush_busy,
  output logic                 pmem_read,
  output logic [ADDR_W-1:0]    pmem_address,
  input  logic                 pmem_resp,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 if_miss,
  output logic                 miss_sig,
  output logic                 hit_evt
);

  localparam int OFF_W   = offset_w(LINE_BITS);
  localparam int IDX_W   = index_w(NUM_SETS);
  localparam int TAG_W   = tag_w(ADDR_W, LINE_BITS, NUM_SETS);
  localparam int WAY_W   = way_w(NUM_WAYS);
  localparam int LADDR_W = ADDR_W - OFF_W;
  localparam int WORDS   = LINE_BITS / 32;

  state_t               state;
  logic                 flush_pend;
  logic [IDX_W-1:0]     flush_cnt;
  logic [LADDR_W-1:0]   fill_addr;
  logic [WAY_W-1:0]     rr_ptr [NUM_SETS];

  logic [IDX_W-1:0]     req_index;
  logic [TAG_W-1:0]     req_tag;
  logic [OFF_W-3:0]     word_sel;
  logic [IDX_W-1:0]     fill_index;
  logic [TAG_W-1:0]     fill_tag;

  logic [NUM_WAYS-1:0]  hit_vec;
  logic [NUM_WAYS-1:0]  fill_valid;
  logic [LINE_BITS-1:0] way_line [NUM_WAYS];
  logic [LINE_BITS-1:0] hit_line;
  logic [WORDS-1:0][31:0] hit_words;
  logic [WAY_W-1:0]     victim;
  logic                 use_rr;

  logic any_hit, lookup, fill_done, flush_req;
  logic unused_addr_bits;

  assign req_index  = mem_address[OFF_W +: IDX_W];
  assign req_tag    = mem_address[ADDR_W-1 -: TAG_W];
  assign word_sel   = mem_address[OFF_W-1:2];
  assign fill_index = fill_addr[IDX_W-1:0];
  assign fill_tag   = fill_addr[LADDR_W-1 -: TAG_W];
  assign unused_addr_bits = &{1'b0, mem_address[1:0]};

  assign flush_req = flush || flush_pend;
  assign lookup    = (state == ST_IDLE) && !flush_req && mem_read;
  assign any_hit   = |hit_vec;
  assign fill_done = (state == ST_FILL) && pmem_resp;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    icache_sa_way #(
      .NUM_SETS  (NUM_SETS),
      .LINE_BITS (LINE_BITS),
      .TAG_W     (TAG_W)
    ) u_way (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_index (req_index),
      .lookup_tag   (req_tag),
      .hit          (hit_vec[w]),
      .lookup_line  (way_line[w]),
      .fill_index   (fill_index),
      .fill_valid   (fill_valid[w]),
      .fill_en      (fill_done && (victim == WAY_W'(w))),
      .fill_tag     (fill_tag),
      .fill_line    (pmem_rdata),
      .clear_en     (state == ST_FLUSH),
      .clear_index  (flush_cnt)
    );
  end

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no path can leave a value held (no latch).
  always_comb begin
    hit_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_vec[w]) hit_line = hit_line | way_line[w];
    end
  end

  // Lowest invalid way wins; only a full set falls back to the round-robin pointer.
  always_comb begin
    victim = rr_ptr[fill_index];
    use_rr = 1'b1;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (use_rr && !fill_valid[w]) begin
        victim = WAY_W'(w);
        use_rr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
      flush_cnt  <= '0;
      fill_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state      <= ST_FLUSH;
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
          end else if (mem_read && !any_hit) begin
            state     <= ST_FILL;
            fill_addr <= mem_address[ADDR_W-1:OFF_W];
          end
        end
        ST_FILL: begin
          if (pmem_resp) begin
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
            state      <= flush_req ? ST_FLUSH : ST_IDLE;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + IDX_W'(1);
          if (&flush_cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else if (state == ST_FLUSH) begin
      rr_ptr[flush_cnt] <= '0;
    end else if (fill_done && use_rr) begin
      rr_ptr[fill_index] <= (NUM_WAYS > 1) ? rr_ptr[fill_index] + WAY_W'(1) : '0;
    end
  end

  assign hit_words    = hit_line;
  assign mem_resp     = lookup && any_hit;
  assign hit_evt      = mem_resp;
  assign if_miss      = lookup && !any_hit;
  assign mem_rdata    = mem_resp ? hit_words[word_sel] : 32'h0;
  assign pmem_read    = (state == ST_FILL);
  assign miss_sig     = pmem_read;
  assign pmem_address = pmem_read ? {fill_addr, {OFF_W{1'b0}}} : '0;
  assign flush_busy   = flush_pend || (state == ST_FLUSH);

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench: default 8x2x256 cache plus a 16x1x128 direct-mapped instance.
module tb_icache_sa;

  logic        clk;
  logic        rst_n;
  logic        mem_read     [2];
  logic [31:0] mem_address  [2];
  logic        flush        [2];
  logic        pmem_resp    [2];
  logic [255:0] pmem_rdata  [2];
  logic        mem_resp     [2];
  logic [31:0] mem_rdata    [2];
  logic        flush_busy   [2];
  logic        pmem_read    [2];
  logic [31:0] pmem_address [2];
  logic        if_miss      [2];
  logic        miss_sig     [2];
  logic        hit_evt      [2];

  int n_checks = 0;
  int n_fail   = 0;

  icache_sa dut_a (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read[0]), .mem_address(mem_address[0]),
    .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0]),
    .flush(flush[0]), .flush_busy(flush_busy[0]),
    .pmem_read(pmem_read[0]), .pmem_address(pmem_address[0]),
    .pmem_resp(pmem_resp[0]), .pmem_rdata(pmem_rdata[0]),
    .if_miss(if_miss[0]), .miss_sig(miss_sig[0]), .hit_evt(hit_evt[0])
  );

  icache_sa #(.NUM_SETS(16), .NUM_WAYS(1), .LINE_BITS(128), .ADDR_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read[1]), .mem_address(mem_address[1]),
    .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1]),
    .flush(flush[1]), .flush_busy(flush_busy[1]),
    .pmem_read(pmem_read[1]), .pmem_address(pmem_address[1]),
    .pmem_resp(pmem_resp[1]), .pmem_rdata(pmem_rdata[1][127:0]),
    .if_miss(if_miss[1]), .miss_sig(miss_sig[1]), .hit_evt(hit_evt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [31:0] addr;
    logic        hit;
    int          lat;
  } vec_t;

  vec_t tab [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int line_bytes(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  // Every word of backing memory carries its own address, so any slip in word select shows.
  function automatic logic [31:0] exp_word(input int d, input logic [31:0] addr);
    logic [31:0] lb = 32'(line_bytes(d));
    logic [31:0] la = addr & ~(lb - 1);
    logic [31:0] w  = (addr & (lb - 1)) >> 2;
    return 32'h5A00_0000 ^ (la << 8) ^ w ^ (32'(d) << 20);
  endfunction

  function automatic logic [255:0] make_line(input int d, input logic [31:0] la);
    logic [255:0] l = '0;
    for (int w = 0; w < line_bytes(d) / 4; w++) l[w*32 +: 32] = exp_word(d, la + 32'(w * 4));
    return l;
  endfunction

  // Called right after the miss cycle was observed; serves the fill after lat FILL cycles.
  task automatic fill_and_resp(input int d, input logic [31:0] addr, input int lat);
    logic [31:0] la = addr & ~(32'(line_bytes(d)) - 1);
    @(posedge clk); #1;
    check($sformatf("pmem_read@%0h", addr), 64'(pmem_read[d]), 64'd1);
    check($sformatf("miss_sig@%0h", addr), 64'(miss_sig[d]), 64'd1);
    check($sformatf("pmem_address@%0h", addr), 64'(pmem_address[d]), 64'(la));
    repeat (lat - 1) @(posedge clk);
    #1;
    pmem_resp[d]  = 1'b1;
    pmem_rdata[d] = make_line(d, la);
    @(posedge clk); #1;
    pmem_resp[d]  = 1'b0;
    pmem_rdata[d] = {8{32'hDEAD_BEEF}};
    #1;
    check($sformatf("fill_resp@%0h", addr), 64'(mem_resp[d]), 64'd1);
    check($sformatf("fill_rdata@%0h", addr), 64'(mem_rdata[d]), 64'(exp_word(d, addr)));
    check($sformatf("fill_pmem_drop@%0h", addr), 64'(pmem_read[d]), 64'd0);
  endtask

  task automatic access(input int d, input logic [31:0] addr, input logic hit, input int lat);
    @(posedge clk); #1;
    mem_read[d]    = 1'b1;
    mem_address[d] = addr;
    #1;
    check($sformatf("resp%0d@%0h", d, addr), 64'(mem_resp[d]), 64'(hit));
    check($sformatf("if_miss%0d@%0h", d, addr), 64'(if_miss[d]), 64'(!hit));
    check($sformatf("hit_evt%0d@%0h", d, addr), 64'(hit_evt[d]), 64'(hit));
    if (hit) check($sformatf("rdata%0d@%0h", d, addr), 64'(mem_rdata[d]), 64'(exp_word(d, addr)));
    else fill_and_resp(d, addr, lat);
  endtask

  // Counts busy cycles from the current sample point; pulses flush again mid-walk.
  task automatic count_flush(input string name);
    int n = 0;
    int resp_seen = 0;
    while (flush_busy[0] && n < 20) begin
      n++;
      if (mem_resp[0]) resp_seen++;
      flush[0] = (n == 3);
      @(posedge clk); #1;
    end
    flush[0] = 1'b0;
    check({name, "_len"}, 64'(n), 64'd8);
    check({name, "_no_resp"}, 64'(resp_seen), 64'd0);
  endtask

  initial begin
    tab = '{
      '{32'h100, 1'b0, 3}, '{32'h104, 1'b1, 0}, '{32'h11C, 1'b1, 0}, '{32'h0E0, 1'b0, 1},
      '{32'h0FC, 1'b1, 0},
      '{32'h000, 1'b0, 2}, '{32'h100, 1'b0, 1}, '{32'h200, 1'b0, 4}, '{32'h100, 1'b1, 0},
      '{32'h208, 1'b1, 0}, '{32'h000, 1'b0, 1}, '{32'h100, 1'b0, 2}, '{32'h00C, 1'b1, 0},
      '{32'h200, 1'b0, 1}, '{32'h11C, 1'b1, 0}, '{32'h0E8, 1'b1, 0}
    };
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mem_read[d] = 1'b0; mem_address[d] = '0; flush[d] = 1'b0;
      pmem_resp[d] = 1'b0; pmem_rdata[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_mem_resp%0d", d), 64'(mem_resp[d]), 64'd0);
      check($sformatf("rst_pmem_read%0d", d), 64'(pmem_read[d]), 64'd0);
      check($sformatf("rst_pmem_addr%0d", d), 64'(pmem_address[d]), 64'd0);
      check($sformatf("rst_flush_busy%0d", d), 64'(flush_busy[d]), 64'd0);
      check($sformatf("rst_if_miss%0d", d), 64'(if_miss[d]), 64'd0);
      check($sformatf("rst_hit_evt%0d", d), 64'(hit_evt[d]), 64'd0);
      check($sformatf("rst_miss_sig%0d", d), 64'(miss_sig[d]), 64'd0);
      check($sformatf("rst_rdata%0d", d), 64'(mem_rdata[d]), 64'd0);
    end
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) access(0, tab[i].addr, tab[i].hit, tab[i].lat);

    // Flush in IDLE beats a simultaneous would-be hit; the held read misses afterwards.
    @(posedge clk); #1;
    mem_read[0] = 1'b1; mem_address[0] = 32'h0E4; flush[0] = 1'b1;
    #1;
    check("flush_prio_resp", 64'(mem_resp[0]), 64'd0);
    check("flush_prio_miss", 64'(if_miss[0]), 64'd0);
    check("flush_pulse_busy", 64'(flush_busy[0]), 64'd0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    count_flush("flush_idle");
    check("post_flush_miss", 64'(if_miss[0]), 64'd1);
    fill_and_resp(0, 32'h0E4, 2);

    for (int i = 5; i < 16; i++) access(0, tab[i].addr, tab[i].hit, tab[i].lat);

    // A stray pmem_resp in IDLE must not disturb the cached line.
    @(posedge clk); #1;
    mem_read[0] = 1'b0; pmem_resp[0] = 1'b1; pmem_rdata[0] = '1;
    #1;
    check("stray_resp_pmem_read", 64'(pmem_read[0]), 64'd0);
    @(posedge clk); #1;
    pmem_resp[0] = 1'b0;
    access(0, 32'h104, 1'b1, 0);

    // Flush during FILL: fill completes, the walk follows, the held read misses again.
    @(posedge clk); #1;
    mem_read[0] = 1'b1; mem_address[0] = 32'h300;
    #1;
    check("ff_miss", 64'(if_miss[0]), 64'd1);
    @(posedge clk); #1;
    flush[0] = 1'b1;
    check("ff_pmem_read", 64'(pmem_read[0]), 64'd1);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    check("ff_pend_busy", 64'(flush_busy[0]), 64'd1);
    check("ff_still_filling", 64'(pmem_read[0]), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    pmem_resp[0] = 1'b1; pmem_rdata[0] = make_line(0, 32'h300);
    @(posedge clk); #1;
    pmem_resp[0] = 1'b0;
    check("ff_no_answer", 64'(mem_resp[0]), 64'd0);
    check("ff_pmem_drop", 64'(pmem_read[0]), 64'd0);
    count_flush("flush_fill");
    check("ff_remiss", 64'(if_miss[0]), 64'd1);
    fill_and_resp(0, 32'h300, 1);

    // Reset mid-FILL: pmem_read drops without a clock, contents are gone afterwards.
    @(posedge clk); #1;
    mem_read[0] = 1'b1; mem_address[0] = 32'h140;
    #1;
    check("rf_miss", 64'(if_miss[0]), 64'd1);
    @(posedge clk); #1;
    check("rf_pmem_read", 64'(pmem_read[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rf_pmem_async", 64'(pmem_read[0]), 64'd0);
    check("rf_pmem_addr", 64'(pmem_address[0]), 64'd0);
    check("rf_flush_busy", 64'(flush_busy[0]), 64'd0);
    mem_read[0] = 1'b0;
    #1 rst_n = 1'b1;
    access(0, 32'h100, 1'b0, 2);
    access(0, 32'h0E8, 1'b0, 1);
    @(posedge clk); #1;
    mem_read[0] = 1'b0;

    // Direct-mapped instance: two lines in set 0 evict each other.
    access(1, 32'h000, 1'b0, 1);
    access(1, 32'h004, 1'b1, 0);
    access(1, 32'h100, 1'b0, 2);
    access(1, 32'h10C, 1'b1, 0);
    access(1, 32'h000, 1'b0, 1);
    access(1, 32'h10C, 1'b0, 1);
    access(1, 32'h104, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative, read-only instruction cache; the next generation of the fixed direct-mapped L1 I-cache.
- Sits between the IF stage and the arbiter / physical-memory port.
- Generalises sets, ways and line width.
- Adds per-set round-robin replacement, a multi-cycle invalidate-all (flush) walk, and hit/miss event outputs for the prefetcher and performance counters.

Parameters:
- NUM_SETS, 8, number of sets; power of 2, ≥2.
- NUM_WAYS, 2, associativity; power of 2, 1..8.
- LINE_BITS, 256, line width in bits; power of 2, ≥64.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  fetch request; held until mem_resp.
- mem_address  in  ADDR_W  byte address; low 2 bits ignored.
- mem_resp  out  1  request done this cycle.
- mem_rdata  out  32  fetched word.
- flush  in  1  single-cycle pulse; invalidate all lines.
- flush_busy  out  1  flush pending or in progress.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_address  out  ADDR_W  line-aligned fill address.
- pmem_resp  in  1  fill data valid.
- pmem_rdata  in  LINE_BITS  fill line.
- if_miss  out  1  one-cycle pulse on the cycle a miss is detected.
- miss_sig  out  1  equals pmem_read.
- hit_evt  out  1  one-cycle pulse per hit response.

Behaviour:
- Address split:
  - offset = log2(LINE_BITS/8) bits.
  - index = log2(NUM_SETS) bits.
  - tag = remaining upper bits.
  - Word select = offset[hi:2].
- Storage (all flops):
  - tag[set][way], valid[set][way], data[set][way].
  - rr_ptr[set], log2(NUM_WAYS) bits; with NUM_WAYS=1 the pointer is constant 0.
- Reset (async):
  - All valid=0, rr_ptr=0, state=IDLE, flush_pend=0.
  - All outputs 0; tag/data are not reset.
- States: IDLE, FILL, FLUSH.
- IDLE:
  - Hit (mem_read and any way valid with tag match): mem_resp=1 and mem_rdata = selected word, combinational in the same cycle; hit_evt=1.
  - Miss: if_miss=1 for that cycle; latch line address; go to FILL next cycle. mem_resp=0.
  - Priority: flush or flush_pend in IDLE goes to FLUSH. It takes precedence over a simultaneous request, which is then not serviced until flush ends.
- FILL:
  - pmem_read=1; pmem_address = {tag,index,0}.
  - On pmem_resp, write pmem_rdata, tag and valid=1 into the first invalid way (lowest index). If no way is invalid, write into way rr_ptr[set] and increment rr_ptr[set] modulo NUM_WAYS.
  - Next state IDLE; the held request hits the following cycle. Miss latency = fill cycles + 2.
  - mem_rdata is don't-care while mem_resp=0.
- FLUSH:
  - Counter walks set 0..NUM_SETS-1, clearing all ways of one set per cycle.
  - Exactly NUM_SETS cycles, then IDLE. rr_ptr is reset to 0 per set.
  - No mem_resp is issued during FLUSH.
- flush_busy = flush_pend or state==FLUSH.
- Flush arriving in FILL: set flush_pend; the fill completes normally (line written); then FLUSH.
  - The held request is not answered from the filled line. After FLUSH it misses again.
- Flush arriving during FLUSH: ignored; no restart.
- mem_read dropping mid-FILL (illegal by protocol): fill still completes and writes the line.
- pmem_resp outside FILL: ignored.
- rst_n asserted mid-FILL or mid-FLUSH: immediate return to reset state. pmem_read drops asynchronously.

Decomposition:
- Package icache_sa_pkg holds:
  - state enum.
  - Helper functions for offset/index/tag width from parameters.
  - Line-address type.
- One sub-module, icache_sa_way (the tag/valid/data array for one way, with hit compare), is instantiated NUM_WAYS times in a generate loop.
- Control FSM, replacement and output mux stay in icache_sa.

Test Plan:
- Defaults; reset; read 0x100 → if_miss pulse, pmem_read with pmem_address=0x100. After pmem_resp, next cycle mem_resp=1 and mem_rdata = line word 0. Read 0x104 → same-cycle hit, hit_evt=1, pmem_read=0.
- Reads 0x000, 0x100, 0x200 (same set 0, 2 ways) → fills into way0, way1, then way0 (rr). A re-read of 0x100 hits; a re-read of 0x000 misses.
- flush pulse in IDLE → flush_busy high exactly 8 cycles. A subsequent read of 0x100 misses.
- flush pulse during FILL, pmem_resp 5 cycles later → line written, FLUSH runs 8 cycles, the held request misses again, and a second fill completes with mem_resp=1.
- rst_n low mid-FILL → pmem_read=0 immediately, all valid cleared. After release, a read of 0x100 misses.
- NUM_WAYS=1, NUM_SETS=16, LINE_BITS=128: read 0x000 then 0x100 (both set 0) → second access evicts; 0x000 misses again.
